regfile_access_ctrl: RTL and testbench

Access sequencer for the register file built from 16-bit dual-read-port registers. It accepts one request per handshake, carrying up to two reads and an optional write. It drives the one-hot per-register ren1/ren2/wen lines and the shared write-data bus, and samples the shared bitlines bl1/bl2. It returns both read words through a valid/ready response channel.

---
 rtl/regfile_access_ctrl.sv | 124 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Access sequencer for a register file of dual-read-port registers: one request per
// handshake, up to two reads then an optional write, result returned on a valid/ready channel.
module regfile_access_ctrl #(
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_waddr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_raddr1,
    input  logic [ADDR_W-1:0] req_raddr2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              rsp_err,
    output logic [NREGS-1:0]  ren1,
    output logic [NREGS-1:0]  ren2,
    output logic [NREGS-1:0]  wen,
    output logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] bl1,
    input  logic [DATA_W-1:0] bl2
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP} state_t;

    state_t              r_state;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_raddr1;
    logic [ADDR_W-1:0]   r_raddr2;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_err;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    // Out-of-range addresses decode to an all-zero enable vector.
    function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = (int'(a) == i);
        return v;
    endfunction

    assign w_err = !in_range(req_raddr1) || !in_range(req_raddr2) ||
                   (req_we && !in_range(req_waddr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
            rsp_err    <= 1'b0;
            ren1       <= '0;
            ren2       <= '0;
            wen        <= '0;
            d          <= '0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_waddr    <= '0;
            r_raddr1   <= '0;
            r_raddr2   <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_waddr   <= req_waddr;
                        r_wdata   <= req_wdata;
                        r_raddr1  <= req_raddr1;
                        r_raddr2  <= req_raddr2;
                        r_err     <= w_err;
                        rsp_err   <= 1'b0;
                        ren1      <= onehot(req_raddr1);
                        ren2      <= onehot(req_raddr2);
                        req_ready <= 1'b0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    rsp_rdata1 <= in_range(r_raddr1) ? bl1 : '0;
                    rsp_rdata2 <= in_range(r_raddr2) ? bl2 : '0;
                    rsp_err    <= r_err;
                    ren1       <= '0;
                    ren2       <= '0;
                    if (r_we) begin
                        wen     <= onehot(r_waddr);
                        d       <= in_range(r_waddr) ? r_wdata : '0;
                        r_state <= S_WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_WRITE: begin
                    wen       <= '0;
                    d         <= '0;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: an 8-register instance plus a 6-register
// instance for out-of-range addressing, each backed by a small register-file model.
module tb_regfile_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // 8-register instance
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_waddr = '0, req_raddr1 = '0, req_raddr2 = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [15:0] rsp_rdata1, rsp_rdata2, d, bl1, bl2;
    logic [7:0]  ren1, ren2, wen;
    logic [15:0] regs [8];

    // 6-register instance
    logic        req_valid6 = 1'b0, req_ready6, req_we6 = 1'b0;
    logic [2:0]  req_waddr6 = '0, req_raddr16 = '0, req_raddr26 = '0;
    logic [15:0] req_wdata6 = '0;
    logic        rsp_valid6, rsp_ready6 = 1'b1, rsp_err6;
    logic [15:0] rsp_rdata16, rsp_rdata26, d6, bl16, bl26;
    logic [5:0]  ren16, ren26, wen6;
    logic [15:0] regs6 [6];

    regfile_access_ctrl #(.NREGS(8), .ADDR_W(3), .DATA_W(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_waddr(req_waddr), .req_wdata(req_wdata), .req_raddr1(req_raddr1),
        .req_raddr2(req_raddr2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2), .rsp_err(rsp_err),
        .ren1(ren1), .ren2(ren2), .wen(wen), .d(d), .bl1(bl1), .bl2(bl2));

    regfile_access_ctrl #(.NREGS(6), .ADDR_W(3), .DATA_W(16)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid6), .req_ready(req_ready6), .req_we(req_we6),
        .req_waddr(req_waddr6), .req_wdata(req_wdata6), .req_raddr1(req_raddr16),
        .req_raddr2(req_raddr26), .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready6),
        .rsp_rdata1(rsp_rdata16), .rsp_rdata2(rsp_rdata26), .rsp_err(rsp_err6),
        .ren1(ren16), .ren2(ren26), .wen(wen6), .d(d6), .bl1(bl16), .bl2(bl26));

    // Register-file models; undriven bitlines float to a garbage pattern.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (wen[i]) regs[i] <= d;
        for (int i = 0; i < 6; i++) if (wen6[i]) regs6[i] <= d6;
    end

    always_comb begin
        bl1 = 16'hBEEF; bl2 = 16'hBEEF; bl16 = 16'hBEEF; bl26 = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            if (ren1[i]) bl1 = regs[i];
            if (ren2[i]) bl2 = regs[i];
        end
        for (int i = 0; i < 6; i++) begin
            if (ren16[i]) bl16 = regs6[i];
            if (ren26[i]) bl26 = regs6[i];
        end
    end

    task automatic send(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        req_we = we; req_waddr = wa; req_wdata = wd; req_raddr1 = a1; req_raddr2 = a2;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send6(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] a1, input logic [2:0] a2);
        @(negedge clk);
        req_we6 = we; req_waddr6 = wa; req_wdata6 = wd; req_raddr16 = a1; req_raddr26 = a2;
        req_valid6 = 1'b1;
        @(posedge clk);
        #1 req_valid6 = 1'b0;
    endtask

    // Records what the controller did over the 8 edges following an accept (k = edges since accept).
    task automatic observe(input logic [7:0] e1, input logic [7:0] e2, output int lat,
                           output int n_wen, output logic [7:0] wen_seen, output logic [15:0] d_seen,
                           output int n_r1, output int n_r2, output int n_bad);
        lat = -1; n_wen = 0; wen_seen = '0; d_seen = '0; n_r1 = 0; n_r2 = 0; n_bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (rsp_valid && lat < 0) lat = k;
            if (wen != 0) begin
                n_wen++; wen_seen = wen; d_seen = d;
                if (ren1 != 0 || ren2 != 0 || $countones(wen) != 1) n_bad++;
            end else if (d != 0) n_bad++;
            if (ren1 != 0) begin if (ren1 == e1) n_r1++; else n_bad++; end
            if (ren2 != 0) begin if (ren2 == e2) n_r2++; else n_bad++; end
        end
    endtask

    task automatic observe6(input logic [5:0] e1, input logic [5:0] e2, output int lat,
                            output int n_wen, output int n_r1, output int n_r2, output int n_bad);
        lat = -1; n_wen = 0; n_r1 = 0; n_r2 = 0; n_bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (rsp_valid6 && lat < 0) lat = k;
            if (wen6 != 0) n_wen++;
            if (ren16 != 0) begin if (ren16 == e1) n_r1++; else n_bad++; end
            if (ren26 != 0) begin if (ren26 == e2) n_r2++; else n_bad++; end
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        n_assert++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
            n_fail++; $display("FAIL reset_ctrl: ready/valid/err=%b required 100", {req_ready, rsp_valid, rsp_err});
        end
        n_assert++;
        if ({rsp_rdata1, rsp_rdata2, d} !== 48'h0) begin
            n_fail++; $display("FAIL reset_data: rdata1=%h rdata2=%h d=%h required 0", rsp_rdata1, rsp_rdata2, d);
        end
        n_assert++;
        if ({ren1, ren2, wen, ren16, ren26, wen6} !== 42'h0) begin
            n_fail++; $display("FAIL reset_enables: ren1=%h ren2=%h wen=%h required 0", ren1, ren2, wen);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_write;
        int lat, n_wen, n_r1, n_r2, n_bad;
        logic [7:0] ws; logic [15:0] ds;
        send(1'b1, 3'd3, 16'hA5C3, 3'd0, 3'd0);
        observe(8'h01, 8'h01, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        n_assert++;
        if (n_wen !== 1 || ws !== 8'h08 || ds !== 16'hA5C3) begin
            n_fail++; $display("FAIL write_pulse: cycles=%0d wen=%h d=%h required 1/08/a5c3", n_wen, ws, ds);
        end
        n_assert++;
        if (lat !== 3) begin n_fail++; $display("FAIL write_latency: %0d required 3", lat); end
        n_assert++;
        if (rsp_err !== 1'b0 || n_bad !== 0) begin
            n_fail++; $display("FAIL write_err_onehot: err=%b bad=%0d required 0/0", rsp_err, n_bad);
        end
        send(1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
        observe(8'h01, 8'h01, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
    endtask

    task automatic test_read;
        int lat, n_wen, n_r1, n_r2, n_bad;
        logic [7:0] ws; logic [15:0] ds;
        send(1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
        observe(8'h08, 8'h20, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        n_assert++;
        if (n_r1 !== 2 || n_r2 !== 2 || n_bad !== 0 || n_wen !== 0) begin
            n_fail++; $display("FAIL read_enables: ren1_cyc=%0d ren2_cyc=%0d bad=%0d wen=%0d required 2/2/0/0", n_r1, n_r2, n_bad, n_wen);
        end
        n_assert++;
        if (lat !== 2) begin n_fail++; $display("FAIL read_latency: %0d required 2", lat); end
        n_assert++;
        if (rsp_rdata1 !== 16'hA5C3 || rsp_rdata2 !== 16'h1234) begin
            n_fail++; $display("FAIL read_data: %h %h required a5c3 1234", rsp_rdata1, rsp_rdata2);
        end
    endtask

    task automatic test_read_before_write;
        int lat, n_wen, n_r1, n_r2, n_bad;
        logic [7:0] ws; logic [15:0] ds;
        send(1'b1, 3'd3, 16'h0001, 3'd0, 3'd0);
        observe(8'h01, 8'h01, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        send(1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3);
        observe(8'h08, 8'h08, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        n_assert++;
        if (rsp_rdata1 !== 16'h0001 || rsp_rdata2 !== 16'h0001) begin
            n_fail++; $display("FAIL rbw_old_value: %h %h required 0001 0001", rsp_rdata1, rsp_rdata2);
        end
        n_assert++;
        if (n_r1 !== 2 || n_r2 !== 2 || n_wen !== 1 || n_bad !== 0 || lat !== 3) begin
            n_fail++; $display("FAIL rbw_sequence: r1=%0d r2=%0d wen=%0d bad=%0d lat=%0d required 2/2/1/0/3", n_r1, n_r2, n_wen, n_bad, lat);
        end
        send(1'b0, 3'd0, 16'h0, 3'd3, 3'd0);
        observe(8'h08, 8'h01, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        n_assert++;
        if (rsp_rdata1 !== 16'hFFFF) begin
            n_fail++; $display("FAIL rbw_new_value: %h required ffff", rsp_rdata1);
        end
    endtask

    task automatic test_backpressure;
        int waited, bad;
        @(negedge clk) rsp_ready = 1'b0;
        send(1'b0, 3'd0, 16'h0, 3'd3, 3'd5);
        waited = 0;
        while (!rsp_valid && waited < 8) begin @(posedge clk); #1; waited++; end
        n_assert++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: rsp_valid=%b required 1", rsp_valid); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata1 !== 16'hFFFF || rsp_rdata2 !== 16'h1234) bad++;
        end
        n_assert++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL bp_hold: %0d unstable cycles (valid=%b ready=%b d1=%h d2=%h) required 0", bad, rsp_valid, req_ready, rsp_rdata1, rsp_rdata2);
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: ready=%b valid=%b required 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_out_of_range;
        int lat, n_wen, n_r1, n_r2, n_bad;
        send6(1'b1, 3'd2, 16'h5A5A, 3'd0, 3'd0);
        observe6(6'h01, 6'h01, lat, n_wen, n_r1, n_r2, n_bad);
        send6(1'b1, 3'd6, 16'h7777, 3'd7, 3'd2);
        observe6(6'h00, 6'b000100, lat, n_wen, n_r1, n_r2, n_bad);
        n_assert++;
        if (n_r1 !== 0 || n_r2 !== 2 || n_wen !== 0 || n_bad !== 0) begin
            n_fail++; $display("FAIL oor_enables: r1=%0d r2=%0d wen=%0d bad=%0d required 0/2/0/0", n_r1, n_r2, n_wen, n_bad);
        end
        n_assert++;
        if (rsp_rdata16 !== 16'h0 || rsp_rdata26 !== 16'h5A5A || rsp_err6 !== 1'b1) begin
            n_fail++; $display("FAIL oor_response: d1=%h d2=%h err=%b required 0000/5a5a/1", rsp_rdata16, rsp_rdata26, rsp_err6);
        end
        n_assert++;
        if (lat !== 3) begin n_fail++; $display("FAIL oor_latency: %0d required 3", lat); end
        send6(1'b0, 3'd0, 16'h0, 3'd1, 3'd2);
        observe6(6'h02, 6'h04, lat, n_wen, n_r1, n_r2, n_bad);
        n_assert++;
        if (rsp_err6 !== 1'b0 || rsp_rdata26 !== 16'h5A5A) begin
            n_fail++; $display("FAIL oor_err_clear: err=%b d2=%h required 0/5a5a", rsp_err6, rsp_rdata26);
        end
    endtask

    task automatic test_reset_in_write;
        int lat, n_wen, n_r1, n_r2, n_bad, waited;
        logic [7:0] ws; logic [15:0] ds;
        logic seen;
        send(1'b1, 3'd6, 16'h1111, 3'd0, 3'd0);
        observe(8'h01, 8'h01, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        send(1'b1, 3'd6, 16'hCAFE, 3'd0, 3'd0);
        waited = 0;
        while (wen == 0 && waited < 6) begin @(posedge clk); #1; waited++; end
        n_assert++;
        if (wen !== 8'h40) begin n_fail++; $display("FAIL rstw_enter: wen=%h required 40", wen); end
        #2 rst = 1'b0;
        #1;
        n_assert++;
        if (wen !== 8'h0 || d !== 16'h0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstw_drop: wen=%h d=%h valid=%b required 0", wen, d, rsp_valid);
        end
        @(negedge clk) rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_assert++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstw_after: rsp_seen=%b ready=%b required 0/1", seen, req_ready);
        end
        send(1'b0, 3'd0, 16'h0, 3'd6, 3'd6);
        observe(8'h40, 8'h40, lat, n_wen, ws, ds, n_r1, n_r2, n_bad);
        n_assert++;
        if (rsp_rdata1 !== 16'h1111) begin
            n_fail++; $display("FAIL rstw_no_write: reg6=%h required 1111", rsp_rdata1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_before_write();
        test_backpressure();
        test_out_of_range();
        test_reset_in_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
